// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory subsystem: address/lane geometry,
// store sizes and the main-memory FSM encoding.
package segre_pkg;

  localparam int ADDR_SIZE         = 32;
  localparam int WORD_SIZE         = 32;
  localparam int DCACHE_LANE_SIZE  = 128;
  localparam int DCACHE_BYTE_SIZE  = 4;   // log2 of bytes per lane
  localparam int DCACHE_LANE_BYTES = DCACHE_LANE_SIZE / 8;

  localparam int MM_LATENCY_DEFAULT = 5;
  localparam int MEM_LANES_DEFAULT  = 4096;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    MM_IDLE = 2'b00,
    MM_WAIT = 2'b01,
    MM_RESP = 2'b10
  } mm_fsm_state_e;

endpackage

// File: rtl/segre_mm_wr_mask.sv
// Store decode: turns size + byte offset + right-justified word into a lane byte-enable
// and lane-positioned data. Sub-word offsets are forced to natural alignment.
module segre_mm_wr_mask
  import segre_pkg::*;
(
  input  memop_data_type_e              data_type,
  input  logic [DCACHE_BYTE_SIZE-1:0]   offset,
  input  logic [WORD_SIZE-1:0]          word,
  output logic [DCACHE_LANE_BYTES-1:0]  byte_en,
  output logic [DCACHE_LANE_SIZE-1:0]   lane_data
);

  logic [DCACHE_BYTE_SIZE-1:0] aligned_off;
  logic [3:0]                  base_en;

  always_comb begin
    aligned_off = offset;
    base_en     = 4'b0000;
    case (data_type)
      BYTE: base_en = 4'b0001;
      HALF: begin
        base_en        = 4'b0011;
        aligned_off[0] = 1'b0;
      end
      WORD: begin
        base_en          = 4'b1111;
        aligned_off[1:0] = 2'b00;
      end
      default: base_en = 4'b0000;
    endcase
  end

  assign byte_en   = {{(DCACHE_LANE_BYTES-4){1'b0}}, base_en} << aligned_off;
  assign lane_data = {{(DCACHE_LANE_SIZE-WORD_SIZE){1'b0}}, word} << {aligned_off, 3'b000};

endmodule

// File: rtl/segre_main_memory.sv
// Lane-wide main memory model: fixed-latency single-outstanding lane reads, byte/half/word
// stores accepted every cycle. Handshake: mm_rd_req_i is a one-cycle pulse honoured only in
// MM_IDLE (otherwise dropped and flagged on mm_err_o); mm_data_rdy_o pulses once with the lane.
module segre_main_memory
  import segre_pkg::*;
#(
  parameter int MEM_LANES  = MEM_LANES_DEFAULT,
  parameter int MM_LATENCY = MM_LATENCY_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mm_rd_req_i,
  input  logic [ADDR_SIZE-1:0]         mm_addr_i,
  input  logic                         mm_wr_req_i,
  input  logic [ADDR_SIZE-1:0]         mm_wr_addr_i,
  input  memop_data_type_e             mm_wr_data_type_i,
  input  logic [WORD_SIZE-1:0]         mm_data_i,
  output logic                         mm_data_rdy_o,
  output logic [DCACHE_LANE_SIZE-1:0]  mm_data_o,
  output logic                         mm_busy_o,
  output logic                         mm_err_o,
  output mm_fsm_state_e                mm_state_o
);

  localparam int LANE_IDX_W = (MEM_LANES > 1) ? $clog2(MEM_LANES) : 1;

  logic [DCACHE_LANE_SIZE-1:0]  mem [MEM_LANES];
  mm_fsm_state_e                state;
  logic [3:0]                   cnt;
  logic [LANE_IDX_W-1:0]        rd_idx;
  logic [LANE_IDX_W-1:0]        req_idx;
  logic [LANE_IDX_W-1:0]        wr_idx;
  logic [DCACHE_LANE_BYTES-1:0] wr_be;
  logic [DCACHE_LANE_SIZE-1:0]  wr_lane;
  logic [DCACHE_LANE_SIZE-1:0]  fwd_lane;
  logic                         unused_addr_bits;

  // Truncating to LANE_IDX_W bits is what makes lane addresses wrap modulo MEM_LANES.
  assign req_idx = mm_addr_i[DCACHE_BYTE_SIZE +: LANE_IDX_W];
  assign wr_idx  = mm_wr_addr_i[DCACHE_BYTE_SIZE +: LANE_IDX_W];
  assign unused_addr_bits = ^{mm_addr_i, mm_wr_addr_i};

  segre_mm_wr_mask u_wr_mask (
    .data_type (mm_wr_data_type_i),
    .offset    (mm_wr_addr_i[DCACHE_BYTE_SIZE-1:0]),
    .word      (mm_data_i),
    .byte_en   (wr_be),
    .lane_data (wr_lane)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i && mm_wr_req_i) begin
      for (int b = 0; b < DCACHE_LANE_BYTES; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_lane[b*8 +: 8];
      end
    end
  end

  // A store landing on the same edge as the response load is merged into the returned lane.
  always_comb begin
    fwd_lane = mem[rd_idx];
    if (mm_wr_req_i && (wr_idx == rd_idx)) begin
      for (int b = 0; b < DCACHE_LANE_BYTES; b++) begin
        if (wr_be[b]) fwd_lane[b*8 +: 8] = wr_lane[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= MM_IDLE;
      cnt       <= 4'd0;
      rd_idx    <= '0;
      mm_data_o <= '0;
      mm_err_o  <= 1'b0;
    end else begin
      case (state)
        MM_IDLE: begin
          if (mm_rd_req_i) begin
            rd_idx <= req_idx;
            cnt    <= 4'(MM_LATENCY - 1);
            state  <= MM_WAIT;
          end
        end
        MM_WAIT: begin
          if (mm_rd_req_i) mm_err_o <= 1'b1;
          if (cnt == 4'd0) begin
            state     <= MM_RESP;
            mm_data_o <= fwd_lane;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        MM_RESP: begin
          if (mm_rd_req_i) mm_err_o <= 1'b1;
          state <= MM_IDLE;
        end
        default: state <= MM_IDLE;
      endcase
    end
  end

  assign mm_data_rdy_o = (state == MM_RESP);
  assign mm_busy_o     = (state != MM_IDLE);
  assign mm_state_o    = state;

endmodule

// File: tb/tb_segre_main_memory.sv
// Directed bench for segre_main_memory: latency, store sizes, same-edge forwarding,
// dropped requests, reset mid-read and address wrap, each against hand-computed lanes.
module tb_segre_main_memory;
  import segre_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        rd_req;
  logic [ADDR_SIZE-1:0]        rd_addr;
  logic                        wr_req;
  logic [ADDR_SIZE-1:0]        wr_addr;
  memop_data_type_e            wr_type;
  logic [WORD_SIZE-1:0]        wr_data;
  logic                        rdy;
  logic [DCACHE_LANE_SIZE-1:0] data;
  logic                        busy;
  logic                        err;
  mm_fsm_state_e               state;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [127:0] LANE10_INIT = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LANE10_MOD  = 128'h00112233_DEADBEEF_8899BEEF_ABDDEEFF;
  localparam logic [127:0] LANE20_FWD  = 128'h44444444_33333333_12345678_11111111;
  localparam logic [127:0] LANE20_B1   = 128'h44444444_33333333_12345678_11115A11;

  segre_main_memory #(.MEM_LANES(4096), .MM_LATENCY(5)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .mm_rd_req_i       (rd_req),
    .mm_addr_i         (rd_addr),
    .mm_wr_req_i       (wr_req),
    .mm_wr_addr_i      (wr_addr),
    .mm_wr_data_type_i (wr_type),
    .mm_data_i         (wr_data),
    .mm_data_rdy_o     (rdy),
    .mm_data_o         (data),
    .mm_busy_o         (busy),
    .mm_err_o          (err),
    .mm_state_o        (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input memop_data_type_e t, input logic [31:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_type = t;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  // Issues a read and waits (bounded) for the rdy pulse; lat = -1 on timeout.
  task automatic do_read(input logic [31:0] a, output int lat, output logic [127:0] d);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    lat = -1;
    d   = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rdy) begin
        lat = c;
        d   = data;
        break;
      end
    end
    tick();
  endtask

  initial begin
    int            lat;
    int            pulses;
    int            first;
    logic [127:0]  d;

    rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_type = BYTE; wr_data = '0;
    tick(); tick();
    chk("reset_rdy",   rdy,   1'b0);
    chk("reset_data",  data,  128'h0);
    chk("reset_busy",  busy,  1'b0);
    chk("reset_err",   err,   1'b0);
    chk("reset_state", state, MM_IDLE);
    rst = 1'b0;

    // Preload lane 0x10 with the reference pattern.
    store(32'h100, WORD, 32'hCCDDEEFF);
    store(32'h104, WORD, 32'h8899AABB);
    store(32'h108, WORD, 32'h44556677);
    store(32'h10C, WORD, 32'h00112233);

    // Latency: request on edge 0, rdy only after edge 5.
    rd_req = 1'b1; rd_addr = 32'h100;
    for (int c = 0; c <= 6; c++) begin
      tick();
      if (c == 0) rd_req = 1'b0;
      chk($sformatf("lat_rdy_c%0d", c), rdy, (c == 5));
      if (c >= 1) chk($sformatf("lat_busy_c%0d", c), busy, (c <= 5));
      if (c == 5) chk("lat_data", data, LANE10_INIT);
    end
    chk("lat_data_held", data, LANE10_INIT);

    // Store sizes with sub-word misalignment forced to natural alignment.
    store(32'h103, BYTE, 32'h000000AB);
    store(32'h105, HALF, 32'h0000BEEF);
    store(32'h10B, WORD, 32'hDEADBEEF);
    do_read(32'h100, lat, d);
    chk("sizes_lat",  lat, 5);
    chk("sizes_data", d,   LANE10_MOD);

    // Same-edge forward: store sampled on the edge that loads the response.
    store(32'h200, WORD, 32'h11111111);
    store(32'h204, WORD, 32'h22222222);
    store(32'h208, WORD, 32'h33333333);
    store(32'h20C, WORD, 32'h44444444);
    rd_req = 1'b1; rd_addr = 32'h200;
    tick();
    rd_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("fwd_rdy_before", rdy, 1'b0);
    store(32'h204, WORD, 32'h12345678);
    chk("fwd_rdy",      rdy,          1'b1);
    chk("fwd_bits6332", data[63:32],  32'h12345678);
    chk("fwd_data",     data,         LANE20_FWD);
    tick();

    // Same-cycle read and store in IDLE: store applies first.
    rd_req = 1'b1; rd_addr = 32'h200;
    wr_req = 1'b1; wr_addr = 32'h201; wr_type = BYTE; wr_data = 32'h0000005A;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    first = -1; d = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (rdy && first < 0) begin first = c; d = data; end
    end
    chk("samecyc_lat",  first, 5);
    chk("samecyc_data", d,     LANE20_B1);

    // Dropped request: second pulse two cycles after the first.
    rd_req = 1'b1; rd_addr = 32'h100;
    tick();
    rd_req = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 32'h200;
    tick();
    rd_req = 1'b0;
    chk("drop_err_set", err, 1'b1);
    pulses = 0; first = -1; d = '0;
    for (int c = 3; c <= 12; c++) begin
      tick();
      if (rdy) begin
        pulses++;
        if (first < 0) begin first = c; d = data; end
      end
    end
    chk("drop_pulses", pulses, 1);
    chk("drop_cycle",  first,  5);
    chk("drop_data",   d,      LANE10_MOD);
    chk("drop_err_sticky", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("drop_err_cleared", err, 1'b0);

    // Reset mid-read, with a store during reset that must be ignored.
    rd_req = 1'b1; rd_addr = 32'h100;
    tick();
    rd_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    wr_req = 1'b1; wr_addr = 32'h100; wr_type = BYTE; wr_data = 32'h00000055;
    tick();
    rst = 1'b0; wr_req = 1'b0;
    chk("rstmid_rdy",   rdy,   1'b0);
    chk("rstmid_data",  data,  128'h0);
    chk("rstmid_busy",  busy,  1'b0);
    chk("rstmid_err",   err,   1'b0);
    chk("rstmid_state", state, MM_IDLE);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rdy) pulses++;
    end
    chk("rstmid_no_pulse", pulses, 0);
    do_read(32'h100, lat, d);
    chk("rstmid_reread_lat",  lat, 5);
    chk("rstmid_reread_data", d,   LANE10_MOD);

    // Address wrap: lane 0x1000 aliases lane 0 with 4096 lanes.
    store(32'h0001_0000, WORD, 32'hCAFEF00D);
    do_read(32'h0000_0000, lat, d);
    chk("wrap_lat",  lat,     5);
    chk("wrap_data", d[31:0], 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
